audio_out_arbiter: RTL and testbench

Sequencer and arbiter that shares the stereo audio-out serializer FIFOs between two sample sources, for example a tone generator and a DMA reader. It accepts left/right sample pairs over valid/ready handshakes. It writes each pair atomically into both channel FIFOs, and only when both FIFOs report free space. It holds off after each write until the registered write-space counts reflect that write.

---
 rtl/audio_out_arbiter_if.sv | 49 ++++
 rtl/audio_out_arbiter.sv | 107 ++++++++++
 tb/tb_audio_out_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_out_arbiter_if.sv
// ---------------------------------------------------------------------------
// audio_out_arbiter_if
//   Bundles the two sample-source handshakes and the stereo FIFO write side
//   used by audio_out_arbiter.
//
//   slave  : arbiter view (sources and FIFO space in; ready and FIFO writes out)
//   master : environment view (sources, FIFOs, or a testbench)
//
//   src{0,1}_left_data/right_data : source sample pair
//   src{0,1}_valid / src{0,1}_ready : per-source valid/ready handshake
//   left/right_channel_fifo_write_space : free words per FIFO (registered upstream)
//   left/right_channel_data(_en)  : FIFO write data and strobe
// ---------------------------------------------------------------------------
interface audio_out_arbiter_if #(
  parameter int AUDIO_DATA_WIDTH = 16
);
  logic [AUDIO_DATA_WIDTH-1:0] src0_left_data;
  logic [AUDIO_DATA_WIDTH-1:0] src0_right_data;
  logic                        src0_valid;
  logic                        src0_ready;
  logic [AUDIO_DATA_WIDTH-1:0] src1_left_data;
  logic [AUDIO_DATA_WIDTH-1:0] src1_right_data;
  logic                        src1_valid;
  logic                        src1_ready;
  logic [7:0]                  left_channel_fifo_write_space;
  logic [7:0]                  right_channel_fifo_write_space;
  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data;
  logic                        left_channel_data_en;
  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data;
  logic                        right_channel_data_en;

  modport slave (
    input  src0_left_data, src0_right_data, src0_valid,
    input  src1_left_data, src1_right_data, src1_valid,
    input  left_channel_fifo_write_space, right_channel_fifo_write_space,
    output src0_ready, src1_ready,
    output left_channel_data, left_channel_data_en,
    output right_channel_data, right_channel_data_en
  );

  modport master (
    output src0_left_data, src0_right_data, src0_valid,
    output src1_left_data, src1_right_data, src1_valid,
    output left_channel_fifo_write_space, right_channel_fifo_write_space,
    input  src0_ready, src1_ready,
    input  left_channel_data, left_channel_data_en,
    input  right_channel_data, right_channel_data_en
  );
endinterface

// File: rtl/audio_out_arbiter.sv
// ---------------------------------------------------------------------------
// audio_out_arbiter
//   Shares the stereo audio-out FIFOs between two sample sources. A left/right
//   pair is accepted from one source at a time (round-robin on ties), written
//   to both FIFOs in the same cycle, and the arbiter then idles for
//   HOLD_CYCLES so the upstream-registered write-space counts catch up before
//   the next grant.
//
//   clk, reset  : clock, asynchronous active-high reset
//   enable      : allows new grants while high (in-flight pair always completes)
//   bus         : source handshakes and FIFO write side (slave modport)
//   last_grant  : source index of the most recently accepted pair
//   pair_count  : number of accepted pairs, wraps at 16 bits
// ---------------------------------------------------------------------------
module audio_out_arbiter #(
  parameter int AUDIO_DATA_WIDTH = 16,
  parameter int HOLD_CYCLES      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  audio_out_arbiter_if.slave  bus,
  output logic                last_grant,
  output logic [15:0]         pair_count
);

  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t         state;
  logic [HCW-1:0] hold_cnt;
  logic           space_ok;
  logic           grant;
  logic           grant_sel;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_sel = 1'b0;
    space_ok  = (bus.left_channel_fifo_write_space  != 8'd0) &&
                (bus.right_channel_fifo_write_space != 8'd0);
    // Tie goes to the source that did not win last time; otherwise the
    // single requester wins.
    if (bus.src0_valid && bus.src1_valid) begin
      grant_sel = ~last_grant;
    end else begin
      grant_sel = bus.src1_valid;
    end
    grant = (state == ARB) && enable && space_ok &&
            (bus.src0_valid || bus.src1_valid);
  end

  assign bus.src0_ready = grant && !grant_sel;
  assign bus.src1_ready = grant &&  grant_sel;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the captured sample registers are reset along with the control
      // state; they are only two words and the outputs must read 0 in reset.
      state                     <= ARB;
      hold_cnt                  <= '0;
      last_grant                <= 1'b1;
      pair_count                <= 16'd0;
      bus.left_channel_data     <= '0;
      bus.right_channel_data    <= '0;
      bus.left_channel_data_en  <= 1'b0;
      bus.right_channel_data_en <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared by default, set only on accept.
      bus.left_channel_data_en  <= 1'b0;
      bus.right_channel_data_en <= 1'b0;
      case (state)
        ARB: begin
          if (grant) begin
            bus.left_channel_data     <= grant_sel ? bus.src1_left_data  : bus.src0_left_data;
            bus.right_channel_data    <= grant_sel ? bus.src1_right_data : bus.src0_right_data;
            bus.left_channel_data_en  <= 1'b1;
            bus.right_channel_data_en <= 1'b1;
            last_grant                <= grant_sel;
            pair_count                <= pair_count + 16'd1;
            state                     <= WRITE;
          end
        end
        WRITE: begin
          hold_cnt <= HCW'(HOLD_CYCLES - 1);
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= ARB;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_out_arbiter.sv
module tb_audio_out_arbiter;
  localparam int W    = 16;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        last_grant;
  logic [15:0] pair_count;

  always #5 clk = ~clk;

  audio_out_arbiter_if #(.AUDIO_DATA_WIDTH(W)) bus ();

  audio_out_arbiter #(.AUDIO_DATA_WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .bus        (bus),
    .last_grant (last_grant),
    .pair_count (pair_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: timing expressed as absolute cycle numbers of the last
  // accept (write one cycle later, next grant HOLD+2 cycles later).
  bit          m_last;
  logic [15:0] m_count;
  int          m_next_ok;
  int          m_en_cyc;
  logic [15:0] m_l, m_r;
  bit          exp_r0, exp_r1;
  int          n_acc = 0;
  int          n_en  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_last    = 1'b1;
    m_count   = 16'd0;
    m_next_ok = cyc;
    m_en_cyc  = -1;
    m_l       = 16'd0;
    m_r       = 16'd0;
  endtask

  task automatic drive(input bit en, input bit v0, input bit v1,
                       input logic [7:0] ls, input logic [7:0] rs);
    enable                             = en;
    bus.src0_valid                     = v0;
    bus.src1_valid                     = v1;
    bus.left_channel_fifo_write_space  = ls;
    bus.right_channel_fifo_write_space = rs;
  endtask

  task automatic set_data(input logic [15:0] l0, input logic [15:0] r0,
                          input logic [15:0] l1, input logic [15:0] r1);
    bus.src0_left_data  = l0;
    bus.src0_right_data = r0;
    bus.src1_left_data  = l1;
    bus.src1_right_data = r1;
  endtask

  // Negedge half of a cycle: predict and compare everything visible now.
  task automatic at_negedge();
    bit ok;
    @(negedge clk);
    ok = (cyc >= m_next_ok) && enable &&
         (bus.left_channel_fifo_write_space != 0) &&
         (bus.right_channel_fifo_write_space != 0);
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    if (ok && bus.src0_valid && bus.src1_valid) begin
      if (m_last) exp_r0 = 1'b1; else exp_r1 = 1'b1;
    end else if (ok && bus.src0_valid) begin
      exp_r0 = 1'b1;
    end else if (ok && bus.src1_valid) begin
      exp_r1 = 1'b1;
    end
    check("src0_ready", bus.src0_ready, exp_r0);
    check("src1_ready", bus.src1_ready, exp_r1);
    check("left_en",    bus.left_channel_data_en,  cyc == m_en_cyc);
    check("right_en",   bus.right_channel_data_en, cyc == m_en_cyc);
    check("left_data",  bus.left_channel_data,  m_l);
    check("right_data", bus.right_channel_data, m_r);
    check("last_grant", last_grant, m_last);
    check("pair_count", pair_count, m_count);
    if ((bus.src0_ready && bus.src0_valid) || (bus.src1_ready && bus.src1_valid)) n_acc++;
    if (bus.left_channel_data_en) n_en++;
  endtask

  // Posedge half: the model accepts the pair it predicted ready for.
  task automatic at_posedge();
    @(posedge clk);
    if ((exp_r0 && bus.src0_valid) || (exp_r1 && bus.src1_valid)) begin
      m_last    = exp_r1;
      m_count   = m_count + 16'd1;
      m_en_cyc  = cyc + 1;
      m_next_ok = cyc + 2 + HOLD;
      m_l       = exp_r1 ? bus.src1_left_data  : bus.src0_left_data;
      m_r       = exp_r1 ? bus.src1_right_data : bus.src0_right_data;
    end
    cyc++;
    #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      at_negedge();
      at_posedge();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    check("rst_en",    bus.left_channel_data_en | bus.right_channel_data_en, 1'b0);
    check("rst_data",  {bus.left_channel_data, bus.right_channel_data}, 32'd0);
    check("rst_last",  last_grant, 1'b1);
    check("rst_count", pair_count, 16'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          r0, r1, en, last;
    logic [15:0] cnt, ldata;
  } vec_t;

  function automatic vec_t mk(bit r0, bit r1, bit en, bit last,
                              logic [15:0] cnt, logic [15:0] ldata);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.en = en; v.last = last; v.cnt = cnt; v.ldata = ldata;
    return v;
  endfunction

  initial begin
    vec_t tbl[14];
    int   a0, e0;

    // Both sources valid continuously from reset: src0, src1, src0, src1,
    // each grant 4 cycles apart, write one cycle after each grant.
    tbl[0]  = mk(1, 0, 0, 1, 0, 16'h0000);
    tbl[1]  = mk(0, 0, 1, 0, 1, 16'h1111);
    tbl[2]  = mk(0, 0, 0, 0, 1, 16'h1111);
    tbl[3]  = mk(0, 0, 0, 0, 1, 16'h1111);
    tbl[4]  = mk(0, 1, 0, 0, 1, 16'h1111);
    tbl[5]  = mk(0, 0, 1, 1, 2, 16'hAAAA);
    tbl[6]  = mk(0, 0, 0, 1, 2, 16'hAAAA);
    tbl[7]  = mk(0, 0, 0, 1, 2, 16'hAAAA);
    tbl[8]  = mk(1, 0, 0, 1, 2, 16'hAAAA);
    tbl[9]  = mk(0, 0, 1, 0, 3, 16'h1111);
    tbl[10] = mk(0, 0, 0, 0, 3, 16'h1111);
    tbl[11] = mk(0, 0, 0, 0, 3, 16'h1111);
    tbl[12] = mk(0, 1, 0, 0, 3, 16'h1111);
    tbl[13] = mk(0, 0, 1, 1, 4, 16'hAAAA);

    reset = 1'b1;
    drive(0, 0, 0, 8'h80, 8'h80);
    set_data(16'h1111, 16'h2222, 16'hAAAA, 16'hBBBB);
    @(posedge clk);
    #1;
    do_reset();

    // Round-robin table
    drive(1, 1, 1, 8'h80, 8'h80);
    for (int i = 0; i < 14; i++) begin
      at_negedge();
      check("tbl_ready0", bus.src0_ready, tbl[i].r0);
      check("tbl_ready1", bus.src1_ready, tbl[i].r1);
      check("tbl_en",     bus.left_channel_data_en & bus.right_channel_data_en, tbl[i].en);
      check("tbl_last",   last_grant, tbl[i].last);
      check("tbl_count",  pair_count, tbl[i].cnt);
      check("tbl_ldata",  bus.left_channel_data, tbl[i].ldata);
      at_posedge();
    end

    // Single source, two pairs
    do_reset();
    a0 = n_acc; e0 = n_en;
    drive(1, 1, 0, 8'h80, 8'h80);
    set_data(16'h1111, 16'h2222, 16'h0, 16'h0);
    tick(1);
    set_data(16'h3333, 16'h4444, 16'h0, 16'h0);
    tick(4);
    drive(1, 0, 0, 8'h80, 8'h80);
    tick(3);
    check("t1_accepts", n_acc - a0, 2);
    check("t1_writes",  n_en - e0, 2);
    check("t1_count",   pair_count, 16'd2);
    check("t1_rdata",   bus.right_channel_data, 16'h4444);

    // Right FIFO full stalls, then one slot frees exactly one accept
    do_reset();
    a0 = n_acc; e0 = n_en;
    set_data(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    drive(1, 1, 1, 8'h80, 8'h00);
    tick(6);
    check("t3_no_accept", n_acc - a0, 0);
    check("t3_no_write",  n_en - e0, 0);
    drive(1, 1, 1, 8'h80, 8'h01);
    tick(4);
    check("t3_one_accept", n_acc - a0, 1);

    // Space drops to 0 two cycles after the write: one write only
    do_reset();
    a0 = n_acc; e0 = n_en;
    drive(1, 1, 0, 8'h01, 8'h01);
    tick(3);
    drive(1, 1, 0, 8'h00, 8'h00);
    tick(6);
    check("t4_accepts", n_acc - a0, 1);
    check("t4_writes",  n_en - e0, 1);

    // enable drops right after an accept
    do_reset();
    a0 = n_acc; e0 = n_en;
    drive(1, 1, 1, 8'h80, 8'h80);
    tick(1);
    drive(0, 1, 1, 8'h80, 8'h80);
    tick(8);
    check("t5_accepts", n_acc - a0, 1);
    check("t5_writes",  n_en - e0, 1);
    drive(1, 1, 1, 8'h80, 8'h80);
    tick(2);
    check("t5_resume", n_acc - a0, 2);

    // Async reset in the WRITE cycle
    do_reset();
    drive(1, 1, 1, 8'h80, 8'h80);
    tick(1);
    check("t6_write_now", bus.left_channel_data_en, 1'b1);
    reset = 1'b1;
    #1;
    check("t6_en_drop", bus.left_channel_data_en | bus.right_channel_data_en, 1'b0);
    check("t6_count",   pair_count, 16'd0);
    check("t6_last",    last_grant, 1'b1);
    #1;
    reset = 1'b0;
    model_reset();
    at_negedge();
    check("t6_src0_wins", bus.src0_ready, 1'b1);
    at_posedge();
    tick(4);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
            ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      set_data(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      tick(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
